rv_wb_arbiter: RTL and testbench
================================

// Module: rv_wb_arbiter
//
// PURPOSE
// Shares the core's single Wishbone-classic master port between the instruction-fetch
// requester (read-only) and the load/store requester (read/write with byte select).
// Sits between rv_fetch / rv_alu3 and the external bus.
// Replaces ad-hoc address/we/sel muxing with a registered grant FSM, a fairness option
// and a bus-timeout error path.
//
// PARAMETERS
// FAIR       0    0: data always wins a tie; 1: tie goes to requester not granted last
// TIMEOUT    255  cycles without i_wb_ack before abort with error; 0 disables timeout
// TIMEOUT_W  8    width of timeout counter; TIMEOUT must be < 2**TIMEOUT_W
//
// PORTS
// i_clk      in   1   clock, all state on rising edge
// i_reset_n  in   1   reset, asynchronous, active-low
// i_ireq     in   1   instruction read request; held until o_iack/o_ierr
// i_iadr     in   32  instruction address
// o_iack     out  1   one-cycle instruction completion pulse
// o_irdata   out  32  instruction data, valid with o_iack
// o_ierr     out  1   one-cycle instruction timeout pulse
// i_dreq     in   1   data request; held until o_dack/o_derr
// i_dadr     in   32  data address
// i_dwdat    in   32  store data
// i_dwe      in   1   1=store, 0=load
// i_dsel     in   4   byte lanes
// o_dack     out  1   one-cycle data completion pulse
// o_drdata   out  32  load data, valid with o_dack
// o_derr     out  1   one-cycle data timeout pulse
// o_wb_adr   out  32  bus address
// o_wb_dat   out  32  bus write data
// i_wb_dat   in   32  bus read data
// o_wb_we    out  1   bus write enable
// o_wb_sel   out  4   bus byte select
// o_wb_stb   out  1   bus strobe
// o_wb_cyc   out  1   bus cycle
// i_wb_ack   in   1   bus acknowledge
// o_grant    out  2   {data,instr} owner, one-hot or 0 when idle
//
// BEHAVIOUR
// - Reset: state IDLE, last-grant=instr, counter 0. All outputs 0, including o_wb_sel.
//   An async assert mid-cycle drops cyc/stb immediately; no ack or err is issued.
// - FSM IDLE -> GNT_D | GNT_I -> IDLE. Arbitration happens only in IDLE.
//   * Only one request pending: grant it.
//   * Both pending: FAIR=0 -> GNT_D; FAIR=1 -> the requester not granted last.
// - Grant edge: latch address, write data, we and sel into bus registers.
//   * Instruction grant drives we=0, sel=4'hF, dat=0.
//   * cyc=stb=1 from the cycle after the request is seen in IDLE (1-cycle latency).
//   * All bus outputs are registered and stable until the cycle ends.
// - In GNT_x, a cycle with i_wb_ack=1:
//   * o_xack=1 combinationally in that same cycle; o_xrdata = i_wb_dat.
//   * Next state IDLE, cyc/stb drop, o_grant=0.
//   * Back-to-back transfers therefore cost one IDLE cycle.
// - o_irdata/o_drdata pass i_wb_dat through; they are undefined without ack.
// - Timeout counter: cleared on entering GNT_x, +1 each GNT cycle without ack.
//   * When count == TIMEOUT-1 and no ack: pulse o_xerr, drop cyc/stb, go to IDLE.
//   * If ack and timeout coincide, ack wins; err is not asserted.
//   * TIMEOUT=0: the counter never aborts.
// - i_wb_ack while IDLE is ignored: no pulses, no state change.
// - Requester drops req mid-grant (illegal): the bus cycle still completes and the
//   ack/err is still pulsed.
// - o_iack/o_dack/o_ierr/o_derr are mutually exclusive; at most one per cycle.
// - The last-grant flag updates on every grant, independent of FAIR.
//
// TESTING
// 1. Reset mid-cycle: assert i_reset_n=0 during GNT_D -> cyc/stb/we=0 immediately;
//    no ack or err; first post-reset i_ireq is granted normally.
// 2. Single fetch: i_ireq=1, i_iadr=0x100, ack 2 cycles after cyc -> o_wb_adr=0x100,
//    sel=F, we=0; o_iack one pulse; o_irdata=i_wb_dat; grant=01 then 00.
// 3. Tie, FAIR=0: i_ireq and i_dreq (store, adr 0x2004, sel 4'b0011, dat 0xA5A5)
//    same cycle -> data served first with those exact bus values, then fetch.
// 4. FAIR=1, both held: three transactions grant I, D, I in order.
// 5. Timeout, TIMEOUT=4: no ack -> o_derr pulses in the 4th GNT cycle; cyc drops next.
//    Ack on that exact cycle instead -> o_dack pulses and no err.
// 6. Stray ack: i_wb_ack=1 while IDLE -> no ack/err pulses, state stays IDLE.

Source files
------------

// File: rtl/rv_wb_arbiter.sv
// Arbitrates the single Wishbone-classic master port between instruction fetch
// and load/store, with registered grant, optional fairness and bus timeout.
module rv_wb_arbiter #(
  parameter int FAIR      = 0,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ireq,
  input  logic [31:0] i_iadr,
  output logic        o_iack,
  output logic [31:0] o_irdata,
  output logic        o_ierr,
  input  logic        i_dreq,
  input  logic [31:0] i_dadr,
  input  logic [31:0] i_dwdat,
  input  logic        i_dwe,
  input  logic [3:0]  i_dsel,
  output logic        o_dack,
  output logic [31:0] o_drdata,
  output logic        o_derr,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  output logic [1:0]  o_grant
);

  // state | meaning
  // IDLE  | no bus cycle; arbitration happens here
  // GNT_I | bus cycle owned by instruction fetch
  // GNT_D | bus cycle owned by load/store
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic TMO_EN   = (TIMEOUT != 0);
  localparam logic FAIR_EN  = (FAIR != 0);

  state_t               state, state_nxt;
  logic                 last_d;
  logic                 cyc_q;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 busy;
  logic                 tmo_hit;
  logic                 grant_edge;

  assign busy       = (state != IDLE);
  assign tmo_hit    = TMO_EN && (cnt == TMO_LAST);
  assign grant_edge = (state == IDLE) && (state_nxt != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // Data wins a tie unless fairness is on and data was granted last.
        if (i_dreq && (!i_ireq || !FAIR_EN || !last_d))
          state_nxt = GNT_D;
        else if (i_ireq)
          state_nxt = GNT_I;
      end
      GNT_I, GNT_D: begin
        if (i_wb_ack || tmo_hit)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      cnt      <= '0;
      cyc_q    <= 1'b0;
      o_wb_adr <= '0;
      o_wb_dat <= '0;
      o_wb_we  <= 1'b0;
      o_wb_sel <= '0;
    end else begin
      state <= state_nxt;
      cyc_q <= (state_nxt != IDLE);

      if (!busy)
        cnt <= '0;
      else if (!i_wb_ack)
        cnt <= cnt + 1'b1;

      if (grant_edge) begin
        last_d <= (state_nxt == GNT_D);
        if (state_nxt == GNT_D) begin
          o_wb_adr <= i_dadr;
          o_wb_dat <= i_dwdat;
          o_wb_we  <= i_dwe;
          o_wb_sel <= i_dsel;
        end else begin
          o_wb_adr <= i_iadr;
          o_wb_dat <= '0;
          o_wb_we  <= 1'b0;
          o_wb_sel <= 4'hF;
        end
      end
    end
  end

  assign o_wb_cyc = cyc_q;
  assign o_wb_stb = cyc_q;
  assign o_grant  = {state == GNT_D, state == GNT_I};

  // Completion is combinational from ack; ack beats a coincident timeout.
  assign o_iack   = (state == GNT_I) && i_wb_ack;
  assign o_dack   = (state == GNT_D) && i_wb_ack;
  assign o_ierr   = (state == GNT_I) && !i_wb_ack && tmo_hit;
  assign o_derr   = (state == GNT_D) && !i_wb_ack && tmo_hit;
  assign o_irdata = i_wb_dat;
  assign o_drdata = i_wb_dat;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed bench: dut0 is FAIR=0/TIMEOUT=4, dut1 is FAIR=1/TIMEOUT=255 with its
// own request/ack lines.
module tb_rv_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ireq = 0, dreq = 0, dwe = 0, ack = 0;
  logic        f_ireq = 0, f_dreq = 0, f_ack = 0;
  logic [31:0] iadr = 0, dadr = 0, dwdat = 0, wb_din = 0;
  logic [3:0]  dsel = 0;

  logic        iack, ierr, dack, derr, we, stb, cyc;
  logic [31:0] irdata, drdata, wadr, wdat;
  logic [3:0]  sel;
  logic [1:0]  grant;

  logic        f_iack, f_ierr, f_dack, f_derr, f_we, f_stb, f_cyc;
  logic [31:0] f_irdata, f_drdata, f_wadr, f_wdat;
  logic [3:0]  f_sel;
  logic [1:0]  f_grant;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv_wb_arbiter #(.FAIR(0), .TIMEOUT(4), .TIMEOUT_W(8)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_ireq(ireq), .i_iadr(iadr), .o_iack(iack), .o_irdata(irdata), .o_ierr(ierr),
    .i_dreq(dreq), .i_dadr(dadr), .i_dwdat(dwdat), .i_dwe(dwe), .i_dsel(dsel),
    .o_dack(dack), .o_drdata(drdata), .o_derr(derr),
    .o_wb_adr(wadr), .o_wb_dat(wdat), .i_wb_dat(wb_din), .o_wb_we(we), .o_wb_sel(sel),
    .o_wb_stb(stb), .o_wb_cyc(cyc), .i_wb_ack(ack), .o_grant(grant));

  rv_wb_arbiter #(.FAIR(1), .TIMEOUT(255), .TIMEOUT_W(8)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_ireq(f_ireq), .i_iadr(iadr), .o_iack(f_iack), .o_irdata(f_irdata), .o_ierr(f_ierr),
    .i_dreq(f_dreq), .i_dadr(dadr), .i_dwdat(dwdat), .i_dwe(dwe), .i_dsel(dsel),
    .o_dack(f_dack), .o_drdata(f_drdata), .o_derr(f_derr),
    .o_wb_adr(f_wadr), .o_wb_dat(f_wdat), .i_wb_dat(wb_din), .o_wb_we(f_we), .o_wb_sel(f_sel),
    .o_wb_stb(f_stb), .o_wb_cyc(f_cyc), .i_wb_ack(f_ack), .o_grant(f_grant));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_cyc", {31'd0, cyc}, 0);
    chk("rst_stb", {31'd0, stb}, 0);
    chk("rst_sel", {28'd0, sel}, 0);
    chk("rst_adr", wadr, 0);
    chk("rst_grant", {30'd0, grant}, 0);
    chk("rst_acks", {28'd0, iack, dack, ierr, derr}, 0);
    rst_n = 1'b1;

    // single fetch
    tick(); ireq = 1; iadr = 32'h100; #1;
    chk("f_idle_grant", {30'd0, grant}, 0);
    chk("f_idle_cyc", {31'd0, cyc}, 0);
    tick(); #1;
    chk("f_cyc", {31'd0, cyc}, 1);
    chk("f_stb", {31'd0, stb}, 1);
    chk("f_adr", wadr, 32'h100);
    chk("f_sel", {28'd0, sel}, 32'hF);
    chk("f_we", {31'd0, we}, 0);
    chk("f_grant", {30'd0, grant}, 1);
    chk("f_iack_early", {31'd0, iack}, 0);
    tick(); #1;
    chk("f_iack_wait", {31'd0, iack}, 0);
    tick(); ack = 1; wb_din = 32'hDEADBEEF; #1;
    chk("f_iack", {31'd0, iack}, 1);
    chk("f_irdata", irdata, 32'hDEADBEEF);
    chk("f_noerr", {29'd0, ierr, dack, derr}, 0);
    tick(); ack = 0; ireq = 0; #1;
    chk("f_end_grant", {30'd0, grant}, 0);
    chk("f_end_cyc", {31'd0, cyc}, 0);
    chk("f_end_iack", {31'd0, iack}, 0);

    // tie with FAIR=0: data first
    tick(); ireq = 1; iadr = 32'h200; dreq = 1; dadr = 32'h2004; dwe = 1;
    dsel = 4'b0011; dwdat = 32'hA5A5; #1;
    tick(); #1;
    chk("t_grant_d", {30'd0, grant}, 2);
    chk("t_adr", wadr, 32'h2004);
    chk("t_dat", wdat, 32'hA5A5);
    chk("t_we", {31'd0, we}, 1);
    chk("t_sel", {28'd0, sel}, 32'h3);
    ack = 1; #1;
    chk("t_dack", {31'd0, dack}, 1);
    chk("t_no_iack", {31'd0, iack}, 0);
    tick(); ack = 0; dreq = 0; #1;
    chk("t_gap_grant", {30'd0, grant}, 0);
    chk("t_gap_cyc", {31'd0, cyc}, 0);
    tick(); #1;
    chk("t_grant_i", {30'd0, grant}, 1);
    chk("t_adr_i", wadr, 32'h200);
    chk("t_we_i", {31'd0, we}, 0);
    chk("t_sel_i", {28'd0, sel}, 32'hF);
    chk("t_dat_i", wdat, 0);
    ack = 1; wb_din = 32'h12345678; #1;
    chk("t_iack", {31'd0, iack}, 1);
    chk("t_irdata", irdata, 32'h12345678);
    tick(); ack = 0; ireq = 0; #1;
    chk("t_end_grant", {30'd0, grant}, 0);

    // timeout at the 4th granted cycle
    tick(); dreq = 1; dwe = 0; dadr = 32'h3000; dsel = 4'hF; #1;
    tick(); #1; chk("to_c1", {31'd0, derr}, 0);
    tick(); #1; chk("to_c2", {31'd0, derr}, 0);
    tick(); #1; chk("to_c3", {31'd0, derr}, 0);
    tick(); #1;
    chk("to_derr", {31'd0, derr}, 1);
    chk("to_cyc_held", {31'd0, cyc}, 1);
    chk("to_no_dack", {31'd0, dack}, 0);
    tick(); dreq = 0; #1;
    chk("to_cyc_drop", {31'd0, cyc}, 0);
    chk("to_derr_once", {31'd0, derr}, 0);
    chk("to_grant_idle", {30'd0, grant}, 0);

    // ack coinciding with timeout wins
    tick(); dreq = 1; #1;
    tick(); tick(); tick(); tick(); ack = 1; #1;
    chk("ta_dack", {31'd0, dack}, 1);
    chk("ta_no_derr", {31'd0, derr}, 0);
    tick(); ack = 0; dreq = 0; #1;
    chk("ta_cyc_drop", {31'd0, cyc}, 0);
    chk("ta_derr_after", {31'd0, derr}, 0);

    // stray ack while idle
    tick(); ack = 1; #1;
    chk("s_pulses", {28'd0, iack, dack, ierr, derr}, 0);
    chk("s_grant", {30'd0, grant}, 0);
    tick(); ack = 0; #1;
    chk("s_still_idle", {30'd0, grant}, 0);
    chk("s_cyc", {31'd0, cyc}, 0);

    // async reset mid data cycle
    tick(); dreq = 1; dwe = 1; dadr = 32'h40; dsel = 4'hF; #1;
    tick(); #1;
    chk("r_cyc_before", {31'd0, cyc}, 1);
    chk("r_we_before", {31'd0, we}, 1);
    #2; rst_n = 0; #1;
    chk("r_cyc", {31'd0, cyc}, 0);
    chk("r_stb", {31'd0, stb}, 0);
    chk("r_we", {31'd0, we}, 0);
    chk("r_pulses", {28'd0, iack, dack, ierr, derr}, 0);
    dreq = 0;
    tick(); rst_n = 1; ireq = 1; iadr = 32'h500; #1;
    tick(); #1;
    chk("r_post_grant", {30'd0, grant}, 1);
    chk("r_post_adr", wadr, 32'h500);
    ack = 1; #1;
    chk("r_post_iack", {31'd0, iack}, 1);
    tick(); ack = 0; ireq = 0; #1;

    // FAIR=1: lone data, then both held -> I, D, I
    tick(); f_dreq = 1; #1;
    tick(); #1;
    chk("fa_lone_d", {30'd0, f_grant}, 2);
    f_ack = 1; #1;
    chk("fa_lone_dack", {31'd0, f_dack}, 1);
    tick(); f_ack = 0; f_dreq = 0; #1;
    tick(); f_ireq = 1; f_dreq = 1; #1;
    tick(); #1;
    chk("fa_1st_i", {30'd0, f_grant}, 1);
    f_ack = 1; #1;
    chk("fa_1st_iack", {31'd0, f_iack}, 1);
    tick(); f_ack = 0; #1;
    chk("fa_gap1", {30'd0, f_grant}, 0);
    tick(); #1;
    chk("fa_2nd_d", {30'd0, f_grant}, 2);
    f_ack = 1; #1;
    chk("fa_2nd_dack", {31'd0, f_dack}, 1);
    tick(); f_ack = 0; #1;
    tick(); #1;
    chk("fa_3rd_i", {30'd0, f_grant}, 1);
    f_ack = 1; #1;
    tick(); f_ack = 0; f_ireq = 0; f_dreq = 0; #1;
    chk("fa_end", {30'd0, f_grant}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
